// File: rtl/bus_mux_reg_pkg.sv
// Shared types and constants for the registered datapath bus multiplexer.
// The optional BUSMUX_PRIORITY_EN build resolves multi-bit selects to the lowest index.
package bus_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int SRC_DIN = 0;
  localparam int SRC_R0  = 1;
  localparam int SRC_R1  = 2;
  localparam int SRC_R2  = 3;
  localparam int SRC_R3  = 4;
  localparam int SRC_R4  = 5;
  localparam int SRC_R5  = 6;
  localparam int SRC_R6  = 7;
  localparam int SRC_PC  = 8;
  localparam int SRC_G   = 9;
  localparam int SRC_MEM = 10;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    if (cnt == ERR_CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + 8'd1;
    end
  endfunction

endpackage

// File: rtl/bus_mux_reg_if.sv
// Bus-side signal bundle of bus_mux_reg: master drives select/sources, slave is the mux.
interface bus_mux_reg_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 11,
  parameter int IDX_W = $clog2(NSRC)
);
  logic                    en;
  logic [NSRC-1:0]         sel;
  logic [NSRC*WIDTH-1:0]   src_flat;
  logic                    err_clr;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic [IDX_W-1:0]        src_idx;
  logic                    sel_err;
  logic [7:0]              err_cnt;

  modport master (
    output en, sel, src_flat, err_clr,
    input  out, out_valid, src_idx, sel_err, err_cnt
  );

  modport slave (
    input  en, sel, src_flat, err_clr,
    output out, out_valid, src_idx, sel_err, err_cnt
  );
endinterface

// File: rtl/bus_mux_reg_onehot_enc.sv
// Combinational select classifier: lowest set index plus zero / one-hot / multi flags.
module onehot_enc #(
  parameter int N     = 11,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_sel,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_is_zero,
  output logic             o_is_onehot,
  output logic             o_is_multi
);

  logic w_single;

  // Scan downward so the last assignment wins and yields the lowest set bit.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_sel[i]) begin
        o_idx = IDX_W'(i);
      end else begin
        o_idx = o_idx;
      end
    end
  end

  assign w_single    = ((i_sel & (i_sel - {{(N-1){1'b0}}, 1'b1})) == '0);
  assign o_is_zero   = ~|i_sel;
  assign o_is_onehot = ~o_is_zero & w_single;
  assign o_is_multi  = ~o_is_zero & ~w_single;

endmodule

// File: rtl/bus_mux_reg.sv
// Registered bus multiplexer with valid pulse, source index and illegal-select FAULT handling.
// Define BUSMUX_PRIORITY_EN to resolve multi-bit selects to the lowest index instead of faulting.
module bus_mux_reg
  import bus_mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NSRC  = 11,
  parameter int IDX_W = $clog2(NSRC)
) (
  input  logic         Clock,
  input  logic         Resetn,
  bus_mux_reg_if.slave bus
);

  logic [IDX_W-1:0] w_idx;
  logic             w_is_zero;
  logic             w_is_onehot;
  logic             w_is_multi;
  logic [31:0]      w_base;
  logic [WIDTH-1:0] w_src;

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_src_idx;
  logic             r_sel_err;
  logic [7:0]       r_err_cnt;

  onehot_enc #(.N(NSRC), .IDX_W(IDX_W)) u_enc (
    .i_sel       (bus.sel),
    .o_idx       (w_idx),
    .o_is_zero   (w_is_zero),
    .o_is_onehot (w_is_onehot),
    .o_is_multi  (w_is_multi)
  );

  assign w_base = 32'(w_idx) * 32'(WIDTH);
  assign w_src  = bus.src_flat[w_base +: WIDTH];

  // Control FSM with all bus outputs registered; err_clr outranks any same-cycle transfer.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_src_idx   <= '0;
      r_sel_err   <= 1'b0;
      r_err_cnt   <= 8'h00;
    end else if (bus.err_clr) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
      r_err_cnt   <= 8'h00;
    end else if (bus.en && !w_is_zero) begin
      case (r_state)
        IDLE, DRIVE: begin
          if (w_is_onehot) begin
            r_out       <= w_src;
            r_src_idx   <= w_idx;
            r_out_valid <= 1'b1;
            r_state     <= DRIVE;
          end else begin
`ifdef BUSMUX_PRIORITY_EN
            r_out       <= w_src;
            r_src_idx   <= w_idx;
            r_out_valid <= 1'b1;
            r_state     <= DRIVE;
            r_err_cnt   <= sat_inc(r_err_cnt);
`else
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b1;
            r_state     <= FAULT;
            r_err_cnt   <= sat_inc(r_err_cnt);
`endif
          end
        end
        FAULT: begin
          r_out_valid <= 1'b0;
          if (w_is_multi) begin
            r_err_cnt <= sat_inc(r_err_cnt);
          end else begin
            r_err_cnt <= r_err_cnt;
          end
        end
        default: begin
          r_state     <= FAULT;
          r_out_valid <= 1'b0;
          r_sel_err   <= 1'b1;
        end
      endcase
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.src_idx   = r_src_idx;
  assign bus.sel_err   = r_sel_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed plus randomized bench for bus_mux_reg against a behavioural select/transfer model.
module tb_bus_mux_reg;
  import bus_mux_pkg::*;

  localparam int WIDTH = 16;
  localparam int NSRC  = 11;
  localparam int IDX_W = $clog2(NSRC);
`ifdef BUSMUX_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic Clock;
  logic Resetn;
  bus_mux_reg_if #(.WIDTH(WIDTH), .NSRC(NSRC), .IDX_W(IDX_W)) bus ();

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .IDX_W(IDX_W)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [WIDTH-1:0] src [NSRC];
  int n_vec;
  int n_err;

  logic [WIDTH-1:0] m_out;
  logic             m_valid;
  int               m_idx;
  logic             m_err;
  int               m_cnt;
  bit               m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},       32'(bus.out),       32'(m_out));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".src_idx"},   32'(bus.src_idx),   32'(m_idx));
    chk({tag, ".sel_err"},   32'(bus.sel_err),   32'(m_err));
    chk({tag, ".err_cnt"},   32'(bus.err_cnt),   32'(m_cnt));
  endtask

  task automatic model_reset();
    m_out = '0; m_valid = 1'b0; m_idx = 0; m_err = 1'b0; m_cnt = 0; m_fault = 1'b0;
  endtask

  // Apply the bus rules for the inputs present at the coming clock edge.
  task automatic model_update();
    int n;
    int low;
    n = $countones(bus.sel);
    low = 0;
    for (int i = NSRC - 1; i >= 0; i--) if (bus.sel[i]) low = i;
    if (bus.err_clr) begin
      m_fault = 1'b0; m_err = 1'b0; m_cnt = 0; m_valid = 1'b0;
    end else if (bus.en && n > 0) begin
      if (m_fault) begin
        m_valid = 1'b0;
        if (n > 1 && m_cnt < 255) m_cnt++;
      end else if (n == 1 || PRIO) begin
        m_out = src[low]; m_idx = low; m_valid = 1'b1;
        if (n > 1 && m_cnt < 255) m_cnt++;
      end else begin
        m_fault = 1'b1; m_err = 1'b1; m_valid = 1'b0;
        if (m_cnt < 255) m_cnt++;
      end
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic en, input logic [NSRC-1:0] sel, input logic clr, input string tag);
    bus.en = en; bus.sel = sel; bus.err_clr = clr;
    for (int i = 0; i < NSRC; i++) bus.src_flat[i*WIDTH +: WIDTH] = src[i];
    model_update();
    @(posedge Clock);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [NSRC-1:0] s;
    n_vec = 0; n_err = 0;
    Resetn = 1'b0;
    bus.en = 1'b0; bus.sel = '0; bus.err_clr = 1'b0; bus.src_flat = '0;
    for (int i = 0; i < NSRC; i++) src[i] = WIDTH'(16'h1000 + 16'(i));
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    check_all("reset");
    @(negedge Clock);
    Resetn = 1'b1;
    #1;

    // Single transfer from R1, then an idle cycle.
    src[SRC_R1] = 16'hBEEF;
    step(1'b1, 11'b00000000100, 1'b0, "t1_xfer");
    chk("t1_out_const", 32'(bus.out), 32'h0000BEEF);
    chk("t1_idx_const", 32'(bus.src_idx), 32'd2);
    step(1'b0, 11'b00000000100, 1'b0, "t1_idle");
    src[SRC_R1] = 16'h5555;
    step(1'b0, 11'b00000000100, 1'b0, "t1_src_change");

    step(1'b1, 11'b00000000000, 1'b0, "t2_zero");

    // Two-bit select: faults by default, priority-resolved in the alternate build.
    src[SRC_R2] = 16'h1234;
    step(1'b1, 11'b01000001000, 1'b0, "t3_multi");
    step(1'b1, 11'b00000010000, 1'b0, "t3_after");
    step(1'b1, 11'b00000010000, 1'b1, "t3_clr");
    step(1'b1, 11'b00000010000, 1'b0, "t3_resume");

    for (int k = 0; k < 300; k++) begin
      bus.en = 1'b1; bus.sel = 11'b01000001000; bus.err_clr = 1'b0;
      model_update();
      @(posedge Clock);
      #1;
    end
    check_all("t5_sat");
    chk("t5_cnt_const", 32'(bus.err_cnt), 32'h000000FF);
    src[SRC_G] = 16'hCAFE;
    step(1'b1, 11'b01000000000, 1'b1, "t5_clr");

    src[SRC_R1] = 16'hBEEF;
    step(1'b1, 11'b00000000100, 1'b0, "t6_pre");
    #3;
    Resetn = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    @(negedge Clock);
    Resetn = 1'b1;
    #1;

    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NSRC; i++) src[i] = WIDTH'($urandom);
      s = '0;
      case ($urandom_range(0, 3))
        0: s = '0;
        1, 2: s[$urandom_range(0, NSRC - 1)] = 1'b1;
        default: s = NSRC'($urandom);
      endcase
      step(1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 7) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
